// File: rtl/vfpu_stream_engine.sv
// Element-wise vector ALU fed by two joined operand streams (A, B) and producing
// one result stream through a two-stage pipeline; jobs are framed by start/done.
module vfpu_stream_engine #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [CNT_WIDTH-1:0]  trans_size_i,
    input  logic                  a_valid_i,
    output logic                  a_ready_o,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_MIN = 3'd3,
        OP_MAX = 3'd4
    } op_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                r_state;
    state_t                w_state_nxt;

    logic [2:0]            r_op;
    logic [CNT_WIDTH-1:0]  r_size;
    logic [CNT_WIDTH-1:0]  r_issue_cnt;
    logic [CNT_WIDTH-1:0]  r_out_cnt;

    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_a;
    logic [DATA_WIDTH-1:0] r_s1_b;
    logic                  r_s2_valid;
    logic [DATA_WIDTH-1:0] r_s2_data;

    logic                  w_run;
    logic                  w_start;
    logic                  w_r_fire;
    logic                  w_out_last;
    logic                  w_s2_load;
    logic                  w_s1_load;
    logic                  w_join;
    logic [DATA_WIDTH-1:0] w_result;

    assign w_run      = (r_state == RUN);
    assign w_start    = (r_state == IDLE) && start_i;
    assign w_r_fire   = r_s2_valid && r_ready_i;
    assign w_out_last = (r_out_cnt + CNT_ONE) == r_size;

    // Each stage refills in the same cycle it drains, so the pipe sustains 1 element/cycle.
    assign w_s2_load  = !r_s2_valid || r_ready_i;
    assign w_s1_load  = !r_s1_valid || w_s2_load;

    // A and B are only ever taken together; the issue limit blocks surplus input.
    assign w_join     = w_run && a_valid_i && b_valid_i &&
                        (r_issue_cnt < r_size) && w_s1_load;

    assign a_ready_o  = w_join;
    assign b_ready_o  = w_join;
    assign r_valid_o  = r_s2_valid;
    assign r_data_o   = r_s2_data;
    assign busy_o     = (r_state != IDLE);
    assign done_o     = (r_state == DONE);

    always_comb begin
        w_result = r_s1_a;
        case (r_op)
            OP_ADD:  w_result = r_s1_a + r_s1_b;
            OP_SUB:  w_result = r_s1_a - r_s1_b;
            OP_MUL:  w_result = DATA_WIDTH'(r_s1_a * r_s1_b);
            OP_MIN:  w_result = ($signed(r_s1_a) < $signed(r_s1_b)) ? r_s1_a : r_s1_b;
            OP_MAX:  w_result = ($signed(r_s1_a) > $signed(r_s1_b)) ? r_s1_a : r_s1_b;
            default: w_result = r_s1_a;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_nxt = (trans_size_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_r_fire && w_out_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (clear_i) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_op        <= '0;
            r_size      <= '0;
            r_issue_cnt <= '0;
            r_out_cnt   <= '0;
        end else if (clear_i) begin
            r_issue_cnt <= '0;
            r_out_cnt   <= '0;
        end else if (w_start) begin
            r_op        <= op_i;
            r_size      <= trans_size_i;
            r_issue_cnt <= '0;
            r_out_cnt   <= '0;
        end else begin
            if (w_join) begin
                r_issue_cnt <= r_issue_cnt + CNT_ONE;
            end
            if (w_r_fire) begin
                r_out_cnt <= r_out_cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else if (clear_i) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= w_join;
                if (w_join) begin
                    r_s1_a <= a_data_i;
                    r_s1_b <= b_data_i;
                end
            end
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= w_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_vfpu_stream_engine.sv
// Directed bench for vfpu_stream_engine: streaming, back-pressure, join skew,
// zero length, clear abort, surplus input and mid-job reset.
module tb_vfpu_stream_engine;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        clear_i = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = '0;
    logic [31:0] trans_size_i = '0;
    logic        a_valid_i = 1'b0;
    logic        a_ready_o;
    logic [31:0] a_data_i = '0;
    logic        b_valid_i = 1'b0;
    logic        b_ready_o;
    logic [31:0] b_data_i = '0;
    logic        r_valid_o;
    logic        r_ready_i = 1'b0;
    logic [31:0] r_data_o;
    logic        busy_o;
    logic        done_o;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    vfpu_stream_engine #(.DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (clear_i),
        .start_i      (start_i),
        .op_i         (op_i),
        .trans_size_i (trans_size_i),
        .a_valid_i    (a_valid_i),
        .a_ready_o    (a_ready_o),
        .a_data_i     (a_data_i),
        .b_valid_i    (b_valid_i),
        .b_ready_o    (b_ready_o),
        .b_data_i     (b_data_i),
        .r_valid_o    (r_valid_o),
        .r_ready_i    (r_ready_i),
        .r_data_o     (r_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic cyc;
        @(posedge clk_i);
        #1;
    endtask

    task automatic pair(input logic av, input logic [31:0] a, input logic bv, input logic [31:0] b);
        a_valid_i = av;
        a_data_i  = a;
        b_valid_i = bv;
        b_data_i  = b;
        #1;
    endtask

    task automatic start_job(input logic [2:0] op, input logic [31:0] size);
        op_i         = op;
        trans_size_i = size;
        start_i      = 1'b1;
        cyc();
        start_i      = 1'b0;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_a_ready", {31'b0, a_ready_o}, 32'd0);
        chk("rst_b_ready", {31'b0, b_ready_o}, 32'd0);
        chk("rst_r_valid", {31'b0, r_valid_o}, 32'd0);
        chk("rst_busy",    {31'b0, busy_o},    32'd0);
        chk("rst_done",    {31'b0, done_o},    32'd0);
        chk("rst_r_data",  r_data_o,           32'd0);
        cyc();
        rst_i = 1'b0;
        cyc();

        // streaming ADD, wrap on last element
        r_ready_i = 1'b1;
        start_job(3'd0, 32'd4);
        chk("add_busy", {31'b0, busy_o}, 32'd1);
        pair(1'b1, 32'd1, 1'b1, 32'd10);
        chk("add_ready0", {31'b0, a_ready_o}, 32'd1);
        chk("add_bready0", {31'b0, b_ready_o}, 32'd1);
        cyc();
        pair(1'b1, 32'd2, 1'b1, 32'd20);
        chk("add_lat_rvalid", {31'b0, r_valid_o}, 32'd0);
        cyc();
        pair(1'b1, 32'd3, 1'b1, 32'd30);
        chk("add_r0_valid", {31'b0, r_valid_o}, 32'd1);
        chk("add_r0", r_data_o, 32'd11);
        cyc();
        pair(1'b1, 32'hFFFF_FFFF, 1'b1, 32'd1);
        chk("add_r1", r_data_o, 32'd22);
        cyc();
        pair(1'b1, 32'd99, 1'b1, 32'd99);
        chk("add_issue_limit", {31'b0, a_ready_o}, 32'd0);
        chk("add_r2", r_data_o, 32'd33);
        cyc();
        pair(1'b0, 32'd0, 1'b0, 32'd0);
        chk("add_r3_wrap", r_data_o, 32'd0);
        chk("add_r3_valid", {31'b0, r_valid_o}, 32'd1);
        chk("add_no_early_done", {31'b0, done_o}, 32'd0);
        cyc();
        chk("add_done", {31'b0, done_o}, 32'd1);
        chk("add_done_busy", {31'b0, busy_o}, 32'd1);
        chk("add_drained", {31'b0, r_valid_o}, 32'd0);
        cyc();
        chk("add_done_pulse", {31'b0, done_o}, 32'd0);
        chk("add_idle", {31'b0, busy_o}, 32'd0);

        // signed MIN with back-pressure
        r_ready_i = 1'b0;
        start_job(3'd3, 32'd2);
        pair(1'b1, 32'hFFFF_FFFB, 1'b1, 32'd3);
        chk("min_ready0", {31'b0, a_ready_o}, 32'd1);
        cyc();
        pair(1'b1, 32'd7, 1'b1, 32'hFFFF_FFFE);
        chk("min_ready1", {31'b0, a_ready_o}, 32'd1);
        cyc();
        pair(1'b1, 32'd1, 1'b1, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("min_stall_valid", {31'b0, r_valid_o}, 32'd1);
            chk("min_stall_data", r_data_o, 32'hFFFF_FFFB);
            chk("min_stall_ready", {31'b0, a_ready_o}, 32'd0);
            cyc();
        end
        pair(1'b0, 32'd0, 1'b0, 32'd0);
        r_ready_i = 1'b1;
        #1;
        chk("min_r0", r_data_o, 32'hFFFF_FFFB);
        cyc();
        chk("min_r1", r_data_o, 32'hFFFF_FFFE);
        chk("min_r1_valid", {31'b0, r_valid_o}, 32'd1);
        cyc();
        chk("min_done", {31'b0, done_o}, 32'd1);
        cyc();

        // join skew: B arrives three cycles after A
        start_job(3'd0, 32'd1);
        pair(1'b1, 32'd5, 1'b0, 32'd0);
        chk("skew_c0", {31'b0, a_ready_o}, 32'd0);
        cyc();
        chk("skew_c1", {31'b0, a_ready_o}, 32'd0);
        cyc();
        chk("skew_c2", {31'b0, b_ready_o}, 32'd0);
        cyc();
        pair(1'b1, 32'd5, 1'b1, 32'd6);
        chk("skew_c3", {31'b0, a_ready_o}, 32'd1);
        cyc();
        chk("skew_one_pair", {31'b0, a_ready_o}, 32'd0);
        pair(1'b0, 32'd0, 1'b0, 32'd0);
        cyc();
        chk("skew_r", r_data_o, 32'd11);
        cyc();
        chk("skew_done", {31'b0, done_o}, 32'd1);
        cyc();

        // zero-length job
        pair(1'b1, 32'd1, 1'b1, 32'd1);
        start_job(3'd0, 32'd0);
        chk("zero_busy", {31'b0, busy_o}, 32'd1);
        chk("zero_done", {31'b0, done_o}, 32'd1);
        chk("zero_ready", {31'b0, a_ready_o}, 32'd0);
        cyc();
        chk("zero_idle", {31'b0, busy_o}, 32'd0);
        chk("zero_done_end", {31'b0, done_o}, 32'd0);
        chk("zero_ready_end", {31'b0, a_ready_o}, 32'd0);
        pair(1'b0, 32'd0, 1'b0, 32'd0);

        // clear overrides start
        clear_i = 1'b1;
        start_job(3'd0, 32'd4);
        clear_i = 1'b0;
        chk("clr_over_start", {31'b0, busy_o}, 32'd0);

        // clear after two of eight elements, then MUL wrap
        start_job(3'd0, 32'd8);
        pair(1'b1, 32'd1, 1'b1, 32'd1);
        cyc();
        pair(1'b1, 32'd2, 1'b1, 32'd2);
        cyc();
        pair(1'b0, 32'd0, 1'b0, 32'd0);
        chk("abort_pre_valid", {31'b0, r_valid_o}, 32'd1);
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        chk("abort_rvalid", {31'b0, r_valid_o}, 32'd0);
        chk("abort_no_done", {31'b0, done_o}, 32'd0);
        chk("abort_idle", {31'b0, busy_o}, 32'd0);
        cyc();
        chk("abort_no_done2", {31'b0, done_o}, 32'd0);
        start_job(3'd2, 32'd1);
        pair(1'b1, 32'h0001_0000, 1'b1, 32'h0001_0000);
        cyc();
        pair(1'b0, 32'd0, 1'b0, 32'd0);
        cyc();
        chk("mul_valid", {31'b0, r_valid_o}, 32'd1);
        chk("mul_wrap", r_data_o, 32'd0);
        cyc();
        chk("mul_done", {31'b0, done_o}, 32'd1);
        cyc();

        // surplus input with pass-through op
        start_job(3'd5, 32'd2);
        pair(1'b1, 32'hDEAD_0001, 1'b1, 32'd7);
        cyc();
        pair(1'b1, 32'h1234_5678, 1'b1, 32'd9);
        cyc();
        pair(1'b1, 32'h0000_AAAA, 1'b1, 32'd1);
        chk("extra_ready_c2", {31'b0, a_ready_o}, 32'd0);
        chk("pass_r0", r_data_o, 32'hDEAD_0001);
        cyc();
        chk("extra_ready_c3", {31'b0, b_ready_o}, 32'd0);
        chk("pass_r1", r_data_o, 32'h1234_5678);
        cyc();
        chk("extra_done", {31'b0, done_o}, 32'd1);
        chk("extra_ready_c4", {31'b0, a_ready_o}, 32'd0);
        cyc();
        chk("extra_ready_idle", {31'b0, a_ready_o}, 32'd0);
        pair(1'b0, 32'd0, 1'b0, 32'd0);

        // reset mid-job, then SUB
        start_job(3'd0, 32'd4);
        pair(1'b1, 32'd4, 1'b1, 32'd4);
        cyc();
        cyc();
        rst_i = 1'b1;
        #1;
        chk("mrst_busy", {31'b0, busy_o}, 32'd0);
        chk("mrst_rvalid", {31'b0, r_valid_o}, 32'd0);
        chk("mrst_ready", {31'b0, a_ready_o}, 32'd0);
        chk("mrst_done", {31'b0, done_o}, 32'd0);
        pair(1'b0, 32'd0, 1'b0, 32'd0);
        cyc();
        rst_i = 1'b0;
        cyc();
        chk("mrst_no_done", {31'b0, done_o}, 32'd0);
        start_job(3'd1, 32'd1);
        pair(1'b1, 32'd10, 1'b1, 32'd3);
        chk("sub_ready", {31'b0, a_ready_o}, 32'd1);
        cyc();
        pair(1'b0, 32'd0, 1'b0, 32'd0);
        cyc();
        chk("sub_r", r_data_o, 32'd7);
        cyc();
        chk("sub_done", {31'b0, done_o}, 32'd1);
        cyc();

        // signed MAX
        start_job(3'd4, 32'd2);
        pair(1'b1, 32'd3, 1'b1, 32'hFFFF_FFF9);
        cyc();
        pair(1'b1, 32'hFFFF_FFFF, 1'b1, 32'd5);
        cyc();
        pair(1'b0, 32'd0, 1'b0, 32'd0);
        chk("max_r0", r_data_o, 32'd3);
        cyc();
        chk("max_r1", r_data_o, 32'd5);
        cyc();
        chk("max_done", {31'b0, done_o}, 32'd1);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
